// File: rtl/morph_filter_3x3.sv
// Streaming 3x3 erode/dilate over a raster frame using two line buffers.
// Neighbours outside the image take the neutral value of the chosen operator.
module morph_filter_3x3 #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = 1
) (
    input  logic              module_clk,
    input  logic              module_rst,
    input  logic              sof,
    input  logic              mode,
    input  logic              data_val,
    input  logic [DATA_W-1:0] row_data,
    output logic              morph_wr_en,
    output logic [DATA_W-1:0] dld_data,
    output logic              busy,
    output logic              frame_err
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H + 2);
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_W);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t            state_q;
    logic              mode_q;
    logic [XW-1:0]     x_q, cx_q, ax, nx;
    logic [YW-1:0]     y_q, cy_q, ay, ny;
    logic [FW-1:0]     f_q;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];
    logic [3:0]        bnd_q;  // {left, right, top, bottom} padding of the centre
    logic              s1_vld_q, wr_en_q, err_q;
    logic [DATA_W-1:0] dld_q, res_d, pad, v, pix;
    logic              accept, trig, out_trig, abort;

    always_comb begin
        abort    = sof && (state_q != IDLE);
        accept   = data_val && (sof || state_q == FILL || state_q == RUN);
        trig     = accept || (state_q == FLUSH && !sof);
        out_trig = !sof && ((state_q == RUN && data_val) || state_q == FLUSH);
        ax       = sof ? '0 : x_q;
        ay       = sof ? '0 : y_q;
        nx       = (ax == X_LAST) ? '0 : ax + 1'b1;
        ny       = (ax == X_LAST) ? ay + 1'b1 : ay;
        pix      = accept ? row_data : '0;
    end

    // Window column c / row r: c=2 and r=2 are the newest column and line.
    always_comb begin
        pad   = mode_q ? '0 : '1;
        res_d = pad;
        v     = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                v = win_q[c][r];
                if ((c == 0 && bnd_q[3]) || (c == 2 && bnd_q[2]) ||
                    (r == 0 && bnd_q[1]) || (r == 2 && bnd_q[0]))
                    v = pad;
                if (mode_q ? (v > res_d) : (v < res_d))
                    res_d = v;
            end
        end
    end

    always_ff @(posedge module_clk) begin
        if (trig) begin
            lb1_q[ax] <= lb0_q[ax];
            lb0_q[ax] <= pix;
        end
    end

    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            f_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            bnd_q    <= '0;
            s1_vld_q <= 1'b0;
            wr_en_q  <= 1'b0;
            err_q    <= 1'b0;
            dld_q    <= '0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    win_q[c][r] <= '0;
        end else begin
            err_q    <= abort;
            wr_en_q  <= s1_vld_q && !abort;
            s1_vld_q <= out_trig;
            if (s1_vld_q)
                dld_q <= res_d;
            if (trig) begin
                for (int c = 0; c < 2; c++)
                    for (int r = 0; r < 3; r++)
                        win_q[c][r] <= win_q[c+1][r];
                win_q[2][0] <= lb1_q[ax];
                win_q[2][1] <= lb0_q[ax];
                win_q[2][2] <= pix;
                x_q <= nx;
                y_q <= ny;
            end else if (sof) begin
                x_q <= '0;
                y_q <= '0;
            end
            if (sof) begin
                mode_q  <= mode;
                cx_q    <= '0;
                cy_q    <= '0;
                f_q     <= '0;
                state_q <= FILL;
            end else begin
                if (out_trig) begin
                    bnd_q <= {cx_q == '0, cx_q == X_LAST, cy_q == '0, cy_q == Y_LAST};
                    cx_q  <= (cx_q == X_LAST) ? '0 : cx_q + 1'b1;
                    if (cx_q == X_LAST)
                        cy_q <= cy_q + 1'b1;
                end
                case (state_q)
                    FILL: if (accept && ax == '0 && ay == YW'(1)) state_q <= RUN;
                    RUN: if (accept && ax == X_LAST && ay == Y_LAST) begin
                        state_q <= FLUSH;
                        f_q     <= '0;
                    end
                    FLUSH: begin
                        f_q <= f_q + 1'b1;
                        if (f_q == F_LAST) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Busy also covers the two-stage output pipeline draining after FLUSH.
    assign busy        = (state_q != IDLE) || s1_vld_q || wr_en_q;
    assign morph_wr_en = wr_en_q;
    assign dld_data    = dld_q;
    assign frame_err   = err_q;
endmodule

// File: tb/tb_morph_filter_3x3.sv
// Scoreboard bench for morph_filter_3x3 on a 4x3 image, binary and 8-bit instances.
module tb_morph_filter_3x3;
    localparam int W = 4, H = 3, N = 12;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sof = 1'b0, mode = 1'b0, dv = 1'b0;
    logic [0:0] px = '0, dout;
    logic       wr, busy, ferr;
    logic       sof8 = 1'b0, mode8 = 1'b0, dv8 = 1'b0;
    logic [7:0] px8 = '0, dout8;
    logic       wr8, busy8, ferr8;

    int errors = 0, checks = 0, cyc = 0;
    int q[$], q8[$];
    int out_cnt = 0, out_cnt8 = 0, last_out = 0, ferr_hi = 0, ferr_cyc = 0;
    int stamp [1024];

    morph_filter_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(1)) u_dut (
        .module_clk(clk), .module_rst(rst), .sof(sof), .mode(mode), .data_val(dv),
        .row_data(px), .morph_wr_en(wr), .dld_data(dout), .busy(busy), .frame_err(ferr));

    morph_filter_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) u_dut8 (
        .module_clk(clk), .module_rst(rst), .sof(sof8), .mode(mode8), .data_val(dv8),
        .row_data(px8), .morph_wr_en(wr8), .dld_data(dout8), .busy(busy8), .frame_err(ferr8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ferr) begin
            ferr_hi++;
            ferr_cyc = cyc;
        end
        if (wr) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got pixel %0d expected no output", dout);
            end else
                chk($sformatf("pixel%0d", out_cnt), int'(dout), q.pop_front());
            if (out_cnt < 1024) stamp[out_cnt] = cyc;
            last_out = cyc;
            out_cnt++;
        end
        if (wr8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out8: got pixel %0h expected no output", dout8);
            end else
                chk($sformatf("pixel8_%0d", out_cnt8), int'(dout8), q8.pop_front());
            out_cnt8++;
        end
    end

    task automatic step(input logic s, input logic d, input logic p);
        sof = s; dv = d; px = p;
        @(posedge clk); #1;
        sof = 1'b0; dv = 1'b0;
    endtask

    task automatic wait_idle(output int fall);
        int i;
        i = 0;
        @(negedge clk);
        while (busy && i < 40) begin
            @(negedge clk);
            i++;
        end
        fall = cyc;
        chk("busy_drain", int'(busy), 0);
    endtask

    // pre = outputs of an aborted frame still expected ahead of this frame's twelve
    task automatic run_frame(input logic [11:0] img, input logic m, input logic [11:0] expv,
                             input bit sep_sof, input bit gaps, input int pre, input string tag);
        int base, fall, in5;
        base = out_cnt;
        in5  = 0;
        for (int k = 0; k < N; k++) q.push_back(int'(expv[k]));
        mode = m;
        if (sep_sof) begin
            step(1'b1, 1'b0, 1'b0);
            mode = ~m;
        end
        for (int k = 0; k < N; k++) begin
            if (gaps && k > 0)
                repeat ($urandom_range(0, 2)) begin
                    mode = ~mode;
                    step(1'b0, 1'b0, 1'b0);
                end
            if (k == 5) in5 = cyc;
            step(k == 0 && !sep_sof, 1'b1, img[k]);
            if (k == 0) mode = ~m;
        end
        wait_idle(fall);
        chk({tag, "_count"}, out_cnt - base, N + pre);
        chk({tag, "_qempty"}, q.size(), 0);
        if (!gaps) begin
            chk({tag, "_latency"}, stamp[base + pre] - in5, 2);
            chk({tag, "_flush_burst"}, stamp[base + pre + 11] - stamp[base + pre + 7], 4);
            chk({tag, "_busy_fall"}, fall - last_out, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] img_a, exp_a, img_b, exp_b, img_c, exp_c, img_d, img_e, exp_e;
        int base, sof_cyc, i;
        // image bit n is pixel n = y*4 + x
        img_a = 12'hFDF; exp_a = 12'h888;  // erode, (1,1)=0
        img_b = 12'h001; exp_b = 12'h033;  // dilate, (0,0)=1
        img_c = 12'h800; exp_c = 12'hCC0;  // dilate, (3,2)=1
        img_d = 12'hFFF;                   // erode, all ones
        img_e = 12'hFFE; exp_e = 12'hFCC;  // erode, (0,0)=0

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", int'(wr), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ferr", int'(ferr), 0);
        chk("rst_wr8", int'(wr8), 0);
        chk("rst_busy8", int'(busy8), 0);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b1, 1'b1);  // data_val in IDLE must be ignored

        run_frame(img_a, 1'b0, exp_a, 1'b0, 1'b0, 0, "erode_a");
        run_frame(img_b, 1'b1, exp_b, 1'b1, 1'b0, 0, "dilate_b");
        run_frame(img_a, 1'b0, exp_a, 1'b0, 1'b1, 0, "erode_a_gaps");
        run_frame(img_c, 1'b1, exp_c, 1'b0, 1'b1, 0, "dilate_c_gaps");
        run_frame(img_d, 1'b0, img_d, 1'b1, 1'b0, 0, "erode_ones");
        run_frame(img_e, 1'b0, exp_e, 1'b0, 1'b0, 0, "erode_e");
        chk("no_ferr_yet", ferr_hi, 0);

        // Abort after 7 pixels: only centre (0,0) (value 0) is out before the sof lands.
        q.push_back(0);
        mode = 1'b0;
        for (int k = 0; k < 7; k++) step(k == 0, 1'b1, img_a[k]);
        sof_cyc = cyc;
        run_frame(img_b, 1'b1, exp_b, 1'b0, 1'b0, 1, "abort_new");
        chk("abort_ferr_width", ferr_hi, 1);
        chk("abort_ferr_time", ferr_cyc - sof_cyc, 1);

        // Reset mid-RUN
        mode = 1'b1;
        for (int k = 0; k < N; k++) q.push_back(int'(exp_b[k]));
        for (int k = 0; k < 8; k++) step(k == 0, 1'b1, img_b[k]);
        rst = 1'b1;
        #1;
        chk("midrst_wr", int'(wr), 0);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ferr", int'(ferr), 0);
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) step(1'b0, 1'b1, 1'b1);
        chk("postrst_idle_busy", int'(busy), 0);
        run_frame(img_a, 1'b0, exp_a, 1'b0, 1'b0, 0, "post_reset");

        // 8-bit erode: centre 0x10 among 0x80
        base = out_cnt8;
        for (int k = 0; k < N; k++) q8.push_back((k % W == W - 1) ? 'h80 : 'h10);
        mode8 = 1'b0;
        for (int k = 0; k < N; k++) begin
            sof8 = (k == 0); dv8 = 1'b1; px8 = (k == 5) ? 8'h10 : 8'h80;
            @(posedge clk); #1;
            sof8 = 1'b0; dv8 = 1'b0; mode8 = 1'b1;
        end
        i = 0;
        @(negedge clk);
        while (busy8 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("gray_busy_drain", int'(busy8), 0);
        chk("gray_count", out_cnt8 - base, N);
        chk("gray_qempty", q8.size(), 0);
        chk("total_ferr", ferr_hi, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/morph_filter_3x3.md
MORPH_FILTER_3X3 -- requirements
Module: morph_filter_3x3

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line (>=3).
REQ-002 Parameter IMG_H, default 480, active lines per frame (>=3).
REQ-003 Parameter DATA_W, default 1, pixel width (1 = binary; >1 = grayscale).
REQ-004 module_clk  in  1  sole clock; all logic on rising edge.
REQ-005 module_rst  in  1  asynchronous, active-high reset.
REQ-006 sof  in  1  one-cycle start-of-frame pulse, coincident with or before the first pixel.
REQ-007 mode  in  1  0 = erode (3x3 min), 1 = dilate (3x3 max); sampled only on sof.
REQ-008 data_val  in  1  input pixel valid; gaps are allowed.
REQ-009 row_data  in  DATA_W  input pixel, raster order.
REQ-010 morph_wr_en  out  1  output pixel valid; doubles as the SDRAM write request.
REQ-011 dld_data  out  DATA_W  processed pixel.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 frame_err  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 Pixels SHALL be counted with x in 0..IMG_W-1 and y in 0..IMG_H-1; linear index n = y*IMG_W + x.
REQ-015 Two line buffers of IMG_W x DATA_W SHALL hold the previous two lines; a 3x3 register window SHALL shift once per accepted or flush pixel.
REQ-016 The output for centre (x,y) SHALL be the min (erode) or max (dilate) of its 3x3 neighbourhood.
REQ-017 Neighbours outside the image SHALL be padded: all-ones for erode, zero for dilate; padding is decided by the column/row counters, never by buffer contents.
REQ-018 The output for linear centre k SHALL be triggered by input index k+IMG_W+1; morph_wr_en SHALL assert exactly 2 clocks after the trigger data_val cycle.
REQ-019 Exactly IMG_W*IMG_H outputs per frame, in raster order, morph_wr_en high for one cycle each.
REQ-020 FSM states: IDLE, FILL, RUN, FLUSH.
REQ-021 IDLE: data_val ignored; sof -> FILL, latch mode, clear counters.
REQ-022 FILL: accept pixels 0..IMG_W; no output; after pixel IMG_W is accepted -> RUN.
REQ-023 RUN: each accepted pixel triggers one output; after pixel IMG_W*IMG_H-1 is accepted -> FLUSH.
REQ-024 FLUSH: generate IMG_W+1 internal trigger cycles back-to-back, one per clock; data_val ignored; after the last one -> IDLE.
REQ-025 sof in FILL, RUN or FLUSH: pulse frame_err, drop all pending outputs of the old frame, relatch mode, clear counters, -> FILL.
REQ-026 sof and data_val in the same cycle: the pixel is index 0 of the new frame.
REQ-027 The mode input SHALL have no effect between sof pulses.
REQ-028 DATA_W>1: unsigned compare; DATA_W=1: reduces to AND (erode) / OR (dilate).

Reset
REQ-029 While module_rst is high: morph_wr_en=0, dld_data=0, busy=0, frame_err=0, FSM=IDLE, counters and window cleared.
REQ-030 Reset asserted mid-frame SHALL discard the frame; no output until the next sof after release.
REQ-031 Line buffer RAM contents need not be cleared; padding guarantees correct output.

Verification (IMG_W=4, IMG_H=3, DATA_W=1 unless stated)
REQ-032 Assert reset mid-RUN -> all outputs 0 the same cycle; the next frame after sof is fully correct (12 outputs).
REQ-033 Erode, all pixels 1 except (1,1)=0 -> outputs 0 at x0..2/y0..2 (9 pixels), 1 at x=3 (3 pixels).
REQ-034 Dilate, only (0,0)=1 -> outputs 1 at (0,0),(1,0),(0,1),(1,1); remaining 8 outputs 0.
REQ-035 Continuous data_val -> first morph_wr_en 2 clocks after input index 5; last 5 outputs contiguous in FLUSH; busy falls the cycle after the 12th output.
REQ-036 Random data_val gaps with the REQ-033 image -> identical 12 values and order; sof after 7 pixels -> frame_err pulse, no further old-frame outputs, new frame yields 12 outputs.
REQ-037 DATA_W=8 erode, centre 0x10, other pixels 0x80 -> the 9 pixels at x0..2/y0..2 output 0x10; x=3 outputs 0x80.
